axil_slave_regfile: RTL and testbench

//   Parametrised AXI4-Lite slave backed by a bank of NUM_REGS registers; successor to the fixed
//   32-bit single-slot slave interface. Adds byte strobes, BRESP/RRESP error reporting,

---
 rtl/axil_pkg.sv | 29 ++
 rtl/axil_strb_reg.sv | 40 ++++
 rtl/axil_slave_regfile.sv | 214 +++++++++++++++++++++
 tb/tb_axil_slave_regfile.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// axil_pkg
// Shared response codes, FSM state encodings and address-decode helpers.
// Revision: 1.0
// ============================================================================
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [0:0] wr_state_t;
  localparam wr_state_t WR_COLLECT = 1'b0;
  localparam wr_state_t WR_RESP    = 1'b1;

  typedef logic [0:0] rd_state_t;
  localparam rd_state_t RD_IDLE = 1'b0;
  localparam rd_state_t RD_DATA = 1'b1;

  function automatic int lsb_of(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int idx_width(input int num_regs);
    return $clog2(num_regs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axil_strb_reg.sv
`default_nettype none
// ============================================================================
// axil_strb_reg
// Single data-width register with per-byte write enables.
// Revision: 1.0
// ============================================================================
module axil_strb_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   q
);

  logic [DATA_WIDTH-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (we && wstrb[b]) begin
        data_d[b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule
`default_nettype wire

// File: rtl/axil_slave_regfile.sv
`default_nettype none
// ============================================================================
// axil_slave_regfile
// AXI4-Lite slave over a bank of byte-strobed registers with read-only slots.
// Revision: 1.0
// ============================================================================
module axil_slave_regfile
  import axil_pkg::*;
#(
  parameter int                ADDR_WIDTH = 32,
  parameter int                DATA_WIDTH = 32,
  parameter int                NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] usr_reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] usr_rd_in,
  output logic [NUM_REGS-1:0]            usr_wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = lsb_of(DATA_WIDTH);
  localparam int IDX_W  = idx_width(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * STRB_W);

  logic [DATA_WIDTH-1:0] reg_val [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_en;

  // ---------------- write channel ----------------
  wr_state_t             wr_state_d, wr_state_q;
  logic                  aw_held_d, aw_held_q;
  logic                  w_held_d, w_held_q;
  logic [ADDR_WIDTH-1:0] awaddr_d, awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
  logic [STRB_W-1:0]     wstrb_d, wstrb_q;
  logic                  bvalid_d, bvalid_q;
  logic [1:0]            bresp_d, bresp_q;
  logic [NUM_REGS-1:0]   wr_pulse_d, wr_pulse_q;

  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_ok;

  assign wr_idx  = awaddr_q[LSB +: IDX_W];
  assign wr_ok   = (awaddr_q < ADDR_LIMIT) && !RO_MASK[wr_idx];
  assign AWREADY = (wr_state_q == WR_COLLECT) && !aw_held_q;
  assign WREADY  = (wr_state_q == WR_COLLECT) && !w_held_q;

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    wr_en      = '0;
    case (wr_state_q)
      WR_COLLECT: begin
        if (AWVALID && AWREADY) begin
          aw_held_d = 1'b1;
          awaddr_d  = AWADDR;
        end
        if (WVALID && WREADY) begin
          w_held_d = 1'b1;
          wdata_d  = WDATA;
          wstrb_d  = WSTRB;
        end
        // Commit happens the cycle after both halves are held, so the
        // pulse, the new register value and BVALID all appear together.
        if (aw_held_q && w_held_q) begin
          if (wr_ok) begin
            wr_en[wr_idx]      = 1'b1;
            wr_pulse_d[wr_idx] = 1'b1;
          end
          bvalid_d   = 1'b1;
          bresp_d    = wr_ok ? RESP_OKAY : RESP_SLVERR;
          wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (BREADY) begin
          bvalid_d   = 1'b0;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = WR_COLLECT;
        end
      end
      default: wr_state_d = WR_COLLECT;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state_q <= WR_COLLECT;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  assign BVALID       = bvalid_q;
  assign BRESP        = bresp_q;
  assign usr_wr_pulse = wr_pulse_q;

  // ---------------- register bank ----------------
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    axil_strb_reg #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_reg (
      .clk  (ACLK),
      .rst  (ARESET),
      .we   (RO_MASK[i] ? 1'b0 : wr_en[i]),
      .wstrb(wstrb_q),
      .wdata(wdata_q),
      .q    (reg_val[i])
    );
    assign usr_reg_out[i*DATA_WIDTH +: DATA_WIDTH] = reg_val[i];
  end

  // ---------------- read channel ----------------
  rd_state_t             rd_state_d, rd_state_q;
  logic                  rvalid_d, rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic [1:0]            rresp_d, rresp_q;

  logic [IDX_W-1:0]      ar_idx;
  logic                  ar_in_range;
  logic [DATA_WIDTH-1:0] rd_word;

  assign ar_idx      = ARADDR[LSB +: IDX_W];
  assign ar_in_range = ARADDR < ADDR_LIMIT;
  assign rd_word     = RO_MASK[ar_idx] ? usr_rd_in[int'(ar_idx)*DATA_WIDTH +: DATA_WIDTH]
                                       : reg_val[ar_idx];
  assign ARREADY     = (rd_state_q == RD_IDLE);

  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (ARVALID) begin
          rvalid_d   = 1'b1;
          rdata_d    = ar_in_range ? rd_word : '0;
          rresp_d    = ar_in_range ? RESP_OKAY : RESP_SLVERR;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (RREADY) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state_q <= RD_IDLE;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign RVALID = rvalid_q;
  assign RDATA  = rdata_q;
  assign RRESP  = rresp_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_slave_regfile.sv
`default_nettype none
// ============================================================================
// tb_axil_slave_regfile
// Directed-vector bench for the AXI4-Lite register file slave.
// Revision: 1.0
// ============================================================================
module tb_axil_slave_regfile;

  localparam int NR = 16;
  localparam int DW = 32;
  localparam int TO = 20;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        AWADDR;
  logic               AWVALID, AWREADY;
  logic [DW-1:0]      WDATA;
  logic [DW/8-1:0]    WSTRB;
  logic               WVALID, WREADY;
  logic [1:0]         BRESP;
  logic               BVALID, BREADY;
  logic [31:0]        ARADDR;
  logic               ARVALID, ARREADY;
  logic [DW-1:0]      RDATA;
  logic [1:0]         RRESP;
  logic               RVALID, RREADY;
  logic [NR*DW-1:0]   usr_reg_out;
  logic [NR*DW-1:0]   usr_rd_in;
  logic [NR-1:0]      usr_wr_pulse;

  axil_slave_regfile #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(DW),
    .NUM_REGS  (NR),
    .RO_MASK   (16'(1 << 3))
  ) dut (
    .ACLK        (clk),
    .ARESET      (rst),
    .AWADDR      (AWADDR),
    .AWVALID     (AWVALID),
    .AWREADY     (AWREADY),
    .WDATA       (WDATA),
    .WSTRB       (WSTRB),
    .WVALID      (WVALID),
    .WREADY      (WREADY),
    .BRESP       (BRESP),
    .BVALID      (BVALID),
    .BREADY      (BREADY),
    .ARADDR      (ARADDR),
    .ARVALID     (ARVALID),
    .ARREADY     (ARREADY),
    .RDATA       (RDATA),
    .RRESP       (RRESP),
    .RVALID      (RVALID),
    .RREADY      (RREADY),
    .usr_reg_out (usr_reg_out),
    .usr_rd_in   (usr_rd_in),
    .usr_wr_pulse(usr_wr_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt [NR];

  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (usr_wr_pulse[i]) pulse_cnt[i]++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_pulses();
    for (int i = 0; i < NR; i++) pulse_cnt[i] = 0;
  endtask

  function automatic int pulse_total();
    int s = 0;
    for (int i = 0; i < NR; i++) s += pulse_cnt[i];
    return s;
  endfunction

  function automatic logic [DW-1:0] reg_out(input int i);
    return usr_reg_out[i*DW +: DW];
  endfunction

  task automatic axi_write(input logic [31:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                           input int bhold, output logic [1:0] resp);
    int n;
    @(negedge clk);
    AWADDR = a; AWVALID = 1'b1;
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    BREADY = (bhold == 0);
    n = 0;
    while (!(AWREADY && WREADY) && n < TO) begin @(negedge clk); n++; end
    if (n >= TO) check("wr_ready_timeout", 0, 1);
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0;
    n = 0;
    while (!BVALID && n < TO) begin @(negedge clk); n++; end
    if (n >= TO) check("bvalid_timeout", 0, 1);
    resp = BRESP;
    if (bhold > 0) begin
      for (int k = 0; k < bhold; k++) begin
        @(negedge clk);
        check("bvalid_hold", BVALID, 1);
        check("bresp_hold", BRESP, resp);
      end
      BREADY = 1'b1;
    end
    @(negedge clk);
    check("bvalid_clear", BVALID, 0);
  endtask

  task automatic axi_read(input logic [31:0] a, input int hold,
                          output logic [DW-1:0] data, output logic [1:0] resp);
    int n;
    @(negedge clk);
    ARADDR = a; ARVALID = 1'b1;
    RREADY = (hold == 0);
    n = 0;
    while (!ARREADY && n < TO) begin @(negedge clk); n++; end
    if (n >= TO) check("arready_timeout", 0, 1);
    @(negedge clk);
    ARVALID = 1'b0;
    n = 0;
    while (!RVALID && n < TO) begin @(negedge clk); n++; end
    if (n >= TO) check("rvalid_timeout", 0, 1);
    data = RDATA;
    resp = RRESP;
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check("rvalid_hold", RVALID, 1);
        check("rdata_hold", RDATA, data);
        check("rresp_hold", RRESP, resp);
      end
      RREADY = 1'b1;
    end
    @(negedge clk);
    check("rvalid_clear", RVALID, 0);
    check("arready_back", ARREADY, 1);
    RREADY = 1'b0;
  endtask

  // One half of the write is offered, then the other three cycles later.
  task automatic split_write(input logic [31:0] a, input logic [DW-1:0] d, input bit w_first);
    @(negedge clk);
    BREADY = 1'b1;
    if (w_first) begin WDATA = d; WSTRB = 4'hF; WVALID = 1'b1; end
    else begin AWADDR = a; AWVALID = 1'b1; end
    check("split_first_ready", w_first ? WREADY : AWREADY, 1);
    @(negedge clk);
    WVALID = 1'b0; AWVALID = 1'b0;
    check("split_first_drop", w_first ? WREADY : AWREADY, 0);
    check("split_other_up", w_first ? AWREADY : WREADY, 1);
    check("split_bvalid_wait0", BVALID, 0);
    repeat (2) begin
      @(negedge clk);
      check("split_bvalid_wait", BVALID, 0);
    end
    if (w_first) begin AWADDR = a; AWVALID = 1'b1; end
    else begin WDATA = d; WSTRB = 4'hF; WVALID = 1'b1; end
    @(negedge clk);
    WVALID = 1'b0; AWVALID = 1'b0;
    check("split_bvalid_early", BVALID, 0);
    @(negedge clk);
    check("split_bvalid", BVALID, 1);
    check("split_bresp", BRESP, 2'b00);
    @(negedge clk);
    check("split_bvalid_clear", BVALID, 0);
    check("split_awready_back", AWREADY, 1);
    check("split_wready_back", WREADY, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]    resp;
    logic [DW-1:0] data;

    rst = 1'b1;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b1; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    for (int i = 0; i < NR; i++)
      usr_rd_in[i*DW +: DW] = (i == 3) ? 32'h0000_CAFE : (32'hA5A5_0000 | 32'(i));
    clear_pulses();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state after power-up
    check("rst_awready", AWREADY, 1);
    check("rst_wready", WREADY, 1);
    check("rst_arready", ARREADY, 1);
    check("rst_bvalid", BVALID, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_rdata", RDATA, 0);

    // T1: reset mid-transaction
    axi_write(32'h04, 32'h0000_0055, 4'hF, 0, resp);
    check("t1_bresp", resp, 2'b00);
    check("t1_reg1", reg_out(1), 32'h0000_0055);
    @(negedge clk);
    AWADDR = 32'h04; AWVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0;
    check("t1_awready_held", AWREADY, 0);
    rst = 1'b1;
    #1;
    check("t1_awready", AWREADY, 1);
    check("t1_wready", WREADY, 1);
    check("t1_arready", ARREADY, 1);
    check("t1_bvalid", BVALID, 0);
    check("t1_rvalid", RVALID, 0);
    check("t1_regs_zero", 64'(|usr_reg_out), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_no_resp", BVALID, 0);

    // T2: full write then read-back
    clear_pulses();
    axi_write(32'h08, 32'h1234_5678, 4'hF, 0, resp);
    check("t2_bresp", resp, 2'b00);
    check("t2_pulse2", pulse_cnt[2], 1);
    check("t2_pulse_total", pulse_total(), 1);
    axi_read(32'h08, 0, data, resp);
    check("t2_rdata", data, 32'h1234_5678);
    check("t2_rresp", resp, 2'b00);

    // T3: partial strobe
    axi_write(32'h08, 32'hAABB_CCDD, 4'b0101, 0, resp);
    check("t3_bresp", resp, 2'b00);
    check("t3_reg2", reg_out(2), 32'h12BB_56DD);
    axi_read(32'h08, 0, data, resp);
    check("t3_rdata", data, 32'h12BB_56DD);

    // T4: W ahead of AW, then AW ahead of W
    clear_pulses();
    split_write(32'h10, 32'h1111_2222, 1'b1);
    split_write(32'h14, 32'h3333_4444, 1'b0);
    check("t4_reg4", reg_out(4), 32'h1111_2222);
    check("t4_reg5", reg_out(5), 32'h3333_4444);
    check("t4_pulse4", pulse_cnt[4], 1);
    check("t4_pulse5", pulse_cnt[5], 1);
    check("t4_pulse_total", pulse_total(), 2);

    // T5: out-of-range address
    clear_pulses();
    axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, 0, resp);
    check("t5_bresp", resp, 2'b10);
    repeat (2) @(negedge clk);
    check("t5_no_pulse", pulse_total(), 0);
    axi_read(32'h40, 0, data, resp);
    check("t5_rdata", data, 0);
    check("t5_rresp", resp, 2'b10);

    // T6: read-only slot, plus stalled response channels
    clear_pulses();
    axi_write(32'h0C, 32'h1234_5678, 4'hF, 0, resp);
    check("t6_bresp", resp, 2'b10);
    check("t6_reg3", reg_out(3), 0);
    check("t6_no_pulse", pulse_total(), 0);
    axi_read(32'h0C, 5, data, resp);
    check("t6_rdata", data, 32'h0000_CAFE);
    check("t6_rresp", resp, 2'b00);
    axi_write(32'h18, 32'h0BAD_F00D, 4'hF, 5, resp);
    check("t6_hold_bresp", resp, 2'b00);
    check("t6_reg6", reg_out(6), 32'h0BAD_F00D);
    check("t6_pulse6", pulse_cnt[6], 1);
    axi_read(32'h18, 0, data, resp);
    check("t6_rdata6", data, 32'h0BAD_F00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
